// File: rtl/pipe_stall_ctrl.sv
// Central stall controller for the 5-stage core.
// Merges ID and EX stall requests into a per-stage stall vector. It also runs
// the EX multi-cycle sequencer, which holds an op in EX for N cycles and
// publishes the phase index, and it counts stalled cycles for debug.
module pipe_stall_ctrl #(
    parameter int MC_CNT_W = 6,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_cycles,
    output logic [5:0]          stall,
    output logic                ex_mc_busy,
    output logic [MC_CNT_W-1:0] ex_mc_phase,
    output logic                ex_mc_last,
    output logic [PERF_W-1:0]   stall_cycles
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Bit order of the vector: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB.
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    logic [0:0]          state;
    logic [MC_CNT_W-1:0] rem;
    logic [MC_CNT_W-1:0] phase;
    logic                mc_stall;
    logic                mc_accept;

    // A start is only a real multi-cycle op when it needs two or more EX cycles.
    assign mc_accept = ex_mc_start && (ex_mc_cycles >= MC_CNT_W'(2));

    // Sequencer stall and last-cycle decode. A frozen sequencer keeps EX held
    // and must not report a result.
    always_comb begin
        mc_stall   = 1'b0;
        ex_mc_last = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                if (mc_accept) begin
                    mc_stall = 1'b1;
                end else if (ex_mc_start) begin
                    ex_mc_last = 1'b1;
                end
            end else begin
                if (stallreq_ex || (rem > MC_CNT_W'(1))) begin
                    mc_stall = 1'b1;
                end else begin
                    ex_mc_last = 1'b1;
                end
            end
        end
    end

    // Stall vector merge. An EX stall subsumes a concurrent ID stall.
    always_comb begin
        stall = STALL_NONE;
        if (!rst) begin
            if (stallreq_ex || mc_stall) begin
                stall = STALL_EX;
            end else if (stallreq_id) begin
                stall = STALL_ID;
            end
        end
    end

    assign ex_mc_busy  = (state == BUSY);
    assign ex_mc_phase = phase;

    // Sequencer state: latch the length on accept, count down while not frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            phase <= '0;
        end else if (state == IDLE) begin
            if (mc_accept) begin
                state <= BUSY;
                rem   <= ex_mc_cycles - MC_CNT_W'(1);
                phase <= MC_CNT_W'(1);
            end
        end else if (!stallreq_ex) begin
            if (rem > MC_CNT_W'(1)) begin
                rem   <= rem - MC_CNT_W'(1);
                phase <= phase + MC_CNT_W'(1);
            end else begin
                state <= IDLE;
                rem   <= '0;
                phase <= '0;
            end
        end
    end

    // Free-running stalled-cycle counter that wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall != STALL_NONE) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline stall controller for the 5-stage core.
- Merges stall requests from ID (load-use, operand not ready) and from EX into the per-stage stall vector. That vector drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Owns the EX-stage multi-cycle sequencer (madd/msub, iterative ops): holds the instruction in EX for N cycles and publishes the current phase index to the ALU.
- Keeps a free-running count of stalled cycles for debug.

Parameters:
- MC_CNT_W, 6, width of the multi-cycle length and phase counters (max op length 63 cycles).
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high (`RstEnable); sampled on posedge clk.
- stallreq_id  input  1  ID requests a stall this cycle (combinational from ID).
- stallreq_ex  input  1  EX requests a stall this cycle, independent of the sequencer.
- ex_mc_start  input  1  instruction now in EX is multi-cycle (combinational from EX decode of ex_aluop).
- ex_mc_cycles  input  MC_CNT_W  total EX cycles the op needs (N); valid with ex_mc_start.
- stall  output  6  stall vector: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; combinational.
- ex_mc_busy  output  1  sequencer in BUSY state (registered).
- ex_mc_phase  output  MC_CNT_W  phase index of the op in EX: 0 on its first EX cycle, k on cycle k.
- ex_mc_last  output  1  current cycle is the final EX cycle of a multi-cycle op; result is valid; combinational.
- stall_cycles  output  PERF_W  count of cycles with stall != 0 (registered, wraps).

Behaviour:
- Reset (rst=1 at posedge):
  - state<=IDLE, rem<=0, phase<=0, stall_cycles<=0.
  - While rst is high, stall=6'b000000 and ex_mc_last=0.
  - Reset mid-operation abandons the op; no stall on the following cycle unless newly requested.
- Sequencer FSM, states IDLE and BUSY:
  - IDLE: ex_mc_phase=0, ex_mc_busy=0.
  - IDLE, ex_mc_start=1 and ex_mc_cycles>=2: mc_stall=1 this cycle; next state BUSY, rem<=ex_mc_cycles-1, phase<=1.
  - IDLE, ex_mc_start=1 and ex_mc_cycles in {0,1}: treated as single-cycle; mc_stall=0, ex_mc_last=1, stay IDLE.
  - IDLE, ex_mc_start=0: mc_stall=0, ex_mc_last=0.
  - BUSY: ex_mc_start and ex_mc_cycles are ignored (no restart, no re-latch).
  - BUSY, rem>1: mc_stall=1, rem<=rem-1, phase<=phase+1.
  - BUSY, rem==1: mc_stall=0, ex_mc_last=1, next state IDLE, phase<=0.
  - Net effect for an N-cycle op entering EX at cycle T:
    - stall[3] high T..T+N-2 (N-1 cycles).
    - ex_mc_last high at T+N-1.
    - ex_mc_phase = 0,1,...,N-1 over T..T+N-1.
- External EX stall in BUSY:
  - stallreq_ex=1 while BUSY freezes the sequencer: rem and phase hold.
  - mc_stall is forced to 1, ex_mc_last=0.
  - The sequencer resumes on the first cycle with stallreq_ex=0.
- Stall vector, priority highest first:
  - stallreq_ex | mc_stall -> 6'b001111 (PC, IF, ID, EX held; EX/MEM gets a bubble).
  - else stallreq_id -> 6'b000111 (ID/EX gets a bubble).
  - else 6'b000000.
  - stallreq_id concurrent with an EX stall is subsumed; no extra cycle is added.
  - Pipeline registers insert a bubble when stall[n]=1 and stall[n+1]=0; this block only generates the vector.
- Perf counter:
  - stall_cycles<=stall_cycles+1 on every non-reset cycle with stall!=0.
  - Wraps to 0 after 2^PERF_W-1.
- Back-to-back multi-cycle ops: a new start is accepted in the cycle immediately after ex_mc_last (state IDLE again); there are no dead cycles.

Test Plan:
- Reset: rst=1 for 2 cycles while stallreq_id=1 and ex_mc_start=1 -> stall=0, ex_mc_busy=0, stall_cycles=0, ex_mc_phase=0.
- ID stall only: stallreq_id=1 for 3 cycles -> stall=6'b000111 for exactly those cycles; stall_cycles=3.
- 2-cycle op: ex_mc_start=1, cycles=2 at T -> stall=6'b001111 at T, ex_mc_last=1 and stall=0 at T+1; phase=0,1; busy=1 only at T+1.
- 5-cycle op with stallreq_id=1 throughout -> stall=6'b001111 T..T+3, 6'b000111 at T+4; phase 0..4; stall_cycles +5.
- Freeze: 4-cycle op, stallreq_ex=1 at T+2 for 2 cycles -> phase holds at 2 for those cycles; ex_mc_last at T+5; stall[3] high T..T+4.
- Abort and edges:
  - rst at T+2 of a 6-cycle op -> state IDLE, stall=0 at T+3.
  - cycles=0 or 1 -> no stall, ex_mc_last=1 for one cycle.
  - stall_cycles preset near 2^PERF_W-1 -> wraps to 0.
